commit_ctrl: RTL and testbench
==============================

Name: commit_ctrl

Overview:
- Single-issue commit stage directly downstream of the write-back stage; consumes its registered control bundle one instruction per cycle.
- Performs architectural register-file and LLbit updates, resolves exception/ERTN/refetch/IDLE events, and issues the global pipeline flush plus the frontend redirect.
- Holds the pipeline through flush drain and IDLE sleep.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_o stays high per event (>=1).
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wb_valid_i  in  1  write-back instruction valid
- wb_pc_i  in  ADDR_W  instruction PC
- wb_excp_i  in  1  instruction carries exception
- wb_excp_num_i  in  16  one-hot-or-more exception vector, bit0 highest priority
- wb_ertn_i  in  1  instruction is ERTN
- wb_idle_i  in  1  instruction is IDLE
- wb_refetch_i  in  1  instruction needs refetch of pc+4
- wb_we_i  in  1  GPR write enable
- wb_waddr_i  in  5  GPR index
- wb_wdata_i  in  32  GPR data
- wb_llbit_we_i  in  1  LLbit write enable
- wb_llbit_value_i  in  1  LLbit write value
- int_pending_i  in  1  enabled interrupt pending (from CSR)
- csr_eentry_i  in  ADDR_W  exception entry
- csr_era_i  in  ADDR_W  exception return address
- reg_we_o  out  1  GPR write enable
- reg_waddr_o  out  5  GPR index
- reg_wdata_o  out  32  GPR data
- llbit_o  out  1  architectural LLbit
- flush_o  out  1  global flush
- redirect_valid_o  out  1  frontend redirect strobe
- redirect_pc_o  out  ADDR_W  redirect target
- excp_commit_o  out  1  exception/interrupt commit strobe to CSR
- excp_code_o  out  4  index of lowest set bit of wb_excp_num_i; 4'hF for interrupt
- excp_pc_o  out  ADDR_W  PC written to ERA
- ertn_commit_o  out  1  ERTN commit strobe
- stall_o  out  1  upstream must not advance
- idle_o  out  1  core sleeping

Behaviour:
- Clock/reset: one clock clk; reset rst asynchronous, active-high. On reset all outputs 0, state RUN, flush counter 0, LLbit 0.
- All outputs registered; event on wb input at cycle N appears at outputs in cycle N+1.
- States: RUN, FLUSH, IDLE.
- RUN, wb_valid_i=1, priority per instruction:
  1. int_pending_i: interrupt attaches to this instruction. No GPR/LLbit write. excp_commit_o=1, excp_code_o=F, excp_pc_o=wb_pc_i, redirect to csr_eentry_i. LLbit cleared. Go to FLUSH.
  2. wb_excp_i: same as interrupt, but excp_code_o=lowest set bit index of wb_excp_num_i (0 if vector is 0). Go to FLUSH.
  3. wb_ertn_i: ertn_commit_o=1, redirect to csr_era_i, LLbit cleared. Go to FLUSH.
  4. wb_refetch_i: normal writes performed, redirect to wb_pc_i+4 (wraps modulo 2^ADDR_W). Go to FLUSH.
  5. wb_idle_i: writes performed, flush_o pulses, no redirect. Go to IDLE.
  6. Otherwise: reg_we_o=wb_we_i & (wb_waddr_i!=0); waddr/wdata pass through; LLbit updated if wb_llbit_we_i. Stay in RUN.
- RUN, wb_valid_i=0: reg_we_o=0, no event; int_pending_i ignored until a valid instruction arrives.
- Strobes (redirect_valid_o, excp_commit_o, ertn_commit_o, reg_we_o) are single-cycle pulses.
- FLUSH: flush_o=1 and stall_o=1 for FLUSH_CYCLES cycles total, counting the entry cycle. All wb inputs ignored. Returns to RUN after the last cycle.
- IDLE: idle_o=1, stall_o=1, wb inputs ignored. On int_pending_i: commit interrupt with excp_pc_o=PC of IDLE+4 (latched on entry), redirect to csr_eentry_i, clear idle_o, go to FLUSH.
- rst asserted mid-FLUSH or mid-IDLE returns immediately to RUN with all outputs 0.
- LLbit is updated only by wb_llbit_we_i on a committed instruction, or cleared by exception/ERTN. An excepting instruction's LLbit write is dropped.

Test Plan:
- Normal write: valid, we=1, waddr=3, wdata=0xDEADBEEF -> next cycle reg_we_o=1, waddr 3, data 0xDEADBEEF. Same with waddr=0 -> reg_we_o=0.
- Exception: valid, excp=1, excp_num=0x0010, pc=0x1C000100, eentry=0x1C008000 -> excp_commit_o=1, code=4, excp_pc=0x1C000100, redirect 0x1C008000, no reg write, flush_o high 2 cycles, stall_o high 2 cycles, inputs during flush ignored.
- Interrupt plus exception on the same instruction -> code=F (interrupt wins). Same with wb_valid_i=0 -> nothing happens.
- ERTN with era=0x1C000200 and LLbit=1 -> ertn_commit_o=1, redirect 0x1C000200, llbit_o=0. Refetch at pc=0xFFFFFFFC -> redirect 0x00000000.
- IDLE at pc=0x1C000300 -> idle_o=1, stall_o=1 for 10 cycles; int_pending_i=1 -> excp_pc=0x1C000304, code=F, redirect eentry, FLUSH, then RUN.
- Assert rst during IDLE and during FLUSH -> all outputs 0 immediately (asynchronously), state RUN.

Source files
------------

// File: rtl/commit_ctrl.sv
// Commit stage: architectural GPR/LLbit update, exception/ERTN/refetch/IDLE resolution, flush and redirect.
// Latency 1 cycle (all outputs registered); holds upstream via stall_o through flush drain and IDLE sleep.
module commit_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid_i,
   input  logic [ADDR_W-1:0] wb_pc_i,
   input  logic              wb_excp_i,
   input  logic [15:0]       wb_excp_num_i,
   input  logic              wb_ertn_i,
   input  logic              wb_idle_i,
   input  logic              wb_refetch_i,
   input  logic              wb_we_i,
   input  logic [4:0]        wb_waddr_i,
   input  logic [31:0]       wb_wdata_i,
   input  logic              wb_llbit_we_i,
   input  logic              wb_llbit_value_i,
   input  logic              int_pending_i,
   input  logic [ADDR_W-1:0] csr_eentry_i,
   input  logic [ADDR_W-1:0] csr_era_i,
   output logic              reg_we_o,
   output logic [4:0]        reg_waddr_o,
   output logic [31:0]       reg_wdata_o,
   output logic              llbit_o,
   output logic              flush_o,
   output logic              redirect_valid_o,
   output logic [ADDR_W-1:0] redirect_pc_o,
   output logic              excp_commit_o,
   output logic [3:0]        excp_code_o,
   output logic [ADDR_W-1:0] excp_pc_o,
   output logic              ertn_commit_o,
   output logic              stall_o,
   output logic              idle_o
);

   typedef enum logic [1:0] {RUN, FLUSH, IDLE} state_t;

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] idle_pc_q;

   logic              reg_we_q;
   logic [4:0]        reg_waddr_q;
   logic [31:0]       reg_wdata_q;
   logic              llbit_q;
   logic              flush_q;
   logic              redirect_valid_q;
   logic [ADDR_W-1:0] redirect_pc_q;
   logic              excp_commit_q;
   logic [3:0]        excp_code_q;
   logic [ADDR_W-1:0] excp_pc_q;
   logic              ertn_commit_q;
   logic              stall_q;
   logic              idle_q;

   logic [3:0]        excp_code_d;
   logic              gpr_we;

   // Scanning high-to-low leaves the lowest set bit's index; an empty vector reports 0.
   always_comb begin
      excp_code_d = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (wb_excp_num_i[i]) excp_code_d = 4'(i);
      end
   end

   assign gpr_we = wb_we_i & (wb_waddr_i != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= RUN;
         cnt_q            <= '0;
         idle_pc_q        <= '0;
         reg_we_q         <= 1'b0;
         reg_waddr_q      <= '0;
         reg_wdata_q      <= '0;
         llbit_q          <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         excp_commit_q    <= 1'b0;
         excp_code_q      <= '0;
         excp_pc_q        <= '0;
         ertn_commit_q    <= 1'b0;
         stall_q          <= 1'b0;
         idle_q           <= 1'b0;
      end else begin
         reg_we_q         <= 1'b0;
         redirect_valid_q <= 1'b0;
         excp_commit_q    <= 1'b0;
         ertn_commit_q    <= 1'b0;
         flush_q          <= 1'b0;
         stall_q          <= 1'b0;
         idle_q           <= 1'b0;
         case (state_q)
            RUN: begin
               if (wb_valid_i) begin
                  if (int_pending_i || wb_excp_i) begin
                     excp_commit_q    <= 1'b1;
                     excp_code_q      <= int_pending_i ? 4'hF : excp_code_d;
                     excp_pc_q        <= wb_pc_i;
                     redirect_valid_q <= 1'b1;
                     redirect_pc_q    <= csr_eentry_i;
                     llbit_q          <= 1'b0;
                     flush_q          <= 1'b1;
                     stall_q          <= 1'b1;
                     cnt_q            <= CNT_INIT;
                     state_q          <= FLUSH;
                  end else if (wb_ertn_i) begin
                     ertn_commit_q    <= 1'b1;
                     redirect_valid_q <= 1'b1;
                     redirect_pc_q    <= csr_era_i;
                     llbit_q          <= 1'b0;
                     flush_q          <= 1'b1;
                     stall_q          <= 1'b1;
                     cnt_q            <= CNT_INIT;
                     state_q          <= FLUSH;
                  end else begin
                     reg_we_q    <= gpr_we;
                     reg_waddr_q <= wb_waddr_i;
                     reg_wdata_q <= wb_wdata_i;
                     if (wb_llbit_we_i) llbit_q <= wb_llbit_value_i;
                     if (wb_refetch_i) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= wb_pc_i + ADDR_W'(4);
                        flush_q          <= 1'b1;
                        stall_q          <= 1'b1;
                        cnt_q            <= CNT_INIT;
                        state_q          <= FLUSH;
                     end else if (wb_idle_i) begin
                        // Wake-up interrupt reports the instruction after IDLE as its return point.
                        idle_pc_q <= wb_pc_i + ADDR_W'(4);
                        flush_q   <= 1'b1;
                        stall_q   <= 1'b1;
                        idle_q    <= 1'b1;
                        state_q   <= IDLE;
                     end
                  end
               end
            end
            FLUSH: begin
               if (cnt_q == '0) begin
                  state_q <= RUN;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
                  flush_q <= 1'b1;
                  stall_q <= 1'b1;
               end
            end
            IDLE: begin
               if (int_pending_i) begin
                  excp_commit_q    <= 1'b1;
                  excp_code_q      <= 4'hF;
                  excp_pc_q        <= idle_pc_q;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= csr_eentry_i;
                  llbit_q          <= 1'b0;
                  flush_q          <= 1'b1;
                  stall_q          <= 1'b1;
                  cnt_q            <= CNT_INIT;
                  state_q          <= FLUSH;
               end else begin
                  idle_q  <= 1'b1;
                  stall_q <= 1'b1;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign reg_we_o         = reg_we_q;
   assign reg_waddr_o      = reg_waddr_q;
   assign reg_wdata_o      = reg_wdata_q;
   assign llbit_o          = llbit_q;
   assign flush_o          = flush_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;
   assign excp_commit_o    = excp_commit_q;
   assign excp_code_o      = excp_code_q;
   assign excp_pc_o        = excp_pc_q;
   assign ertn_commit_o    = ertn_commit_q;
   assign stall_o          = stall_q;
   assign idle_o           = idle_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Bench for commit_ctrl: directed scenarios then random traffic against a time-based reference model.
module tb_commit_ctrl;
   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid_i, wb_excp_i, wb_ertn_i, wb_idle_i, wb_refetch_i, wb_we_i;
   logic [31:0] wb_pc_i, wb_wdata_i, csr_eentry_i, csr_era_i;
   logic [15:0] wb_excp_num_i;
   logic [4:0]  wb_waddr_i;
   logic        wb_llbit_we_i, wb_llbit_value_i, int_pending_i;
   logic        reg_we_o, llbit_o, flush_o, redirect_valid_o, excp_commit_o, ertn_commit_o, stall_o, idle_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o, redirect_pc_o, excp_pc_o;
   logic [3:0]  excp_code_o;

   always #5 clk = ~clk;

   commit_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i), .wb_excp_i(wb_excp_i), .wb_excp_num_i(wb_excp_num_i),
      .wb_ertn_i(wb_ertn_i), .wb_idle_i(wb_idle_i), .wb_refetch_i(wb_refetch_i), .wb_we_i(wb_we_i),
      .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_llbit_we_i(wb_llbit_we_i),
      .wb_llbit_value_i(wb_llbit_value_i), .int_pending_i(int_pending_i),
      .csr_eentry_i(csr_eentry_i), .csr_era_i(csr_era_i),
      .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .llbit_o(llbit_o),
      .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .excp_commit_o(excp_commit_o), .excp_code_o(excp_code_o), .excp_pc_o(excp_pc_o),
      .ertn_commit_o(ertn_commit_o), .stall_o(stall_o), .idle_o(idle_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference model: edge counter k; wb inputs sampled at edge k are ignored while k <= flush_end.
   int          k = 0;
   int          flush_end = -10;
   bit          m_idle = 1'b0;
   logic [31:0] m_idle_pc = '0;
   bit          m_ll = 1'b0;
   bit          e_we, e_rv, e_commit, e_ertn, e_flush, e_stall, e_idle;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata, e_rpc, e_epc;
   logic [3:0]  e_code;

   function automatic logic [3:0] low_bit(input logic [15:0] v);
      logic [15:0] iso;
      if (v == 16'd0) return 4'd0;
      iso = v & (~v + 16'd1);
      return 4'($countones(iso - 16'd1));
   endfunction

   task automatic model_reset();
      flush_end = -10;
      m_idle    = 1'b0;
      m_ll      = 1'b0;
   endtask

   task automatic predict();
      e_we = 0; e_rv = 0; e_commit = 0; e_ertn = 0; e_stall = 0; e_idle = 0;
      e_waddr = '0; e_wdata = '0; e_rpc = '0; e_epc = '0; e_code = '0;
      if (m_idle) begin
         e_idle = 1; e_stall = 1;
         if (int_pending_i) begin
            e_idle = 0; e_commit = 1; e_code = 4'hF; e_epc = m_idle_pc;
            e_rv = 1; e_rpc = csr_eentry_i; m_ll = 0; m_idle = 0; flush_end = k + FC;
         end
      end else if (k > flush_end && wb_valid_i) begin
         if (int_pending_i || wb_excp_i) begin
            e_commit = 1; e_code = int_pending_i ? 4'hF : low_bit(wb_excp_num_i);
            e_epc = wb_pc_i; e_rv = 1; e_rpc = csr_eentry_i; m_ll = 0; flush_end = k + FC;
         end else if (wb_ertn_i) begin
            e_ertn = 1; e_rv = 1; e_rpc = csr_era_i; m_ll = 0; flush_end = k + FC;
         end else begin
            e_we = wb_we_i && wb_waddr_i != 0; e_waddr = wb_waddr_i; e_wdata = wb_wdata_i;
            if (wb_llbit_we_i) m_ll = wb_llbit_value_i;
            if (wb_refetch_i) begin
               e_rv = 1; e_rpc = wb_pc_i + 32'd4; flush_end = k + FC;
            end else if (wb_idle_i) begin
               m_idle = 1; m_idle_pc = wb_pc_i + 32'd4; e_idle = 1; flush_end = k + 1;
            end
         end
      end
      e_flush = (k < flush_end);
      e_stall = e_stall | e_flush;
   endtask

   task automatic step();
      predict();
      @(posedge clk);
      #1;
      k++;
      chk("reg_we", reg_we_o, e_we);
      if (e_we) begin
         chk("reg_waddr", reg_waddr_o, e_waddr);
         chk("reg_wdata", reg_wdata_o, e_wdata);
      end
      chk("flush", flush_o, e_flush);
      chk("stall", stall_o, e_stall);
      chk("idle", idle_o, e_idle);
      chk("llbit", llbit_o, m_ll);
      chk("redirect_valid", redirect_valid_o, e_rv);
      chk("excp_commit", excp_commit_o, e_commit);
      chk("ertn_commit", ertn_commit_o, e_ertn);
      if (e_rv) chk("redirect_pc", redirect_pc_o, e_rpc);
      if (e_commit) begin
         chk("excp_code", excp_code_o, e_code);
         chk("excp_pc", excp_pc_o, e_epc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_strobes"}, {reg_we_o, flush_o, redirect_valid_o, excp_commit_o, ertn_commit_o, stall_o, idle_o, llbit_o}, 0);
      chk({tag, "_code_waddr"}, {excp_code_o, reg_waddr_o}, 0);
      chk({tag, "_wdata"}, reg_wdata_o, 0);
      chk({tag, "_rpc"}, redirect_pc_o, 0);
      chk({tag, "_epc"}, excp_pc_o, 0);
   endtask

   task automatic clear_in();
      wb_valid_i = 0; wb_excp_i = 0; wb_excp_num_i = '0; wb_ertn_i = 0; wb_idle_i = 0;
      wb_refetch_i = 0; wb_we_i = 0; wb_waddr_i = '0; wb_wdata_i = '0;
      wb_llbit_we_i = 0; wb_llbit_value_i = 0; int_pending_i = 0; wb_pc_i = '0;
   endtask

   task automatic garbage_in();
      wb_valid_i = 1; wb_we_i = 1; wb_waddr_i = 5'd7; wb_wdata_i = 32'h12345678;
      wb_llbit_we_i = 1; wb_llbit_value_i = 1; wb_refetch_i = 1; wb_pc_i = 32'h1C000500;
   endtask

   task automatic mid_cycle_reset(input string tag);
      #2 rst = 1'b1;
      #1 chk_zero(tag);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      clear_in();
   endtask

   initial begin
      clear_in();
      csr_eentry_i = 32'h1C008000;
      csr_era_i    = 32'h1C000200;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_zero("reset");
      rst = 1'b0;

      // Normal writes, including the r0 suppression.
      wb_valid_i = 1; wb_we_i = 1; wb_waddr_i = 5'd3; wb_wdata_i = 32'hDEADBEEF;
      step();
      chk("wr_data_const", reg_wdata_o, 32'hDEADBEEF);
      wb_waddr_i = 5'd0;
      step();
      chk("wr_r0_const", reg_we_o, 0);

      // Exception; inputs during the drain must be ignored.
      clear_in();
      wb_valid_i = 1; wb_excp_i = 1; wb_excp_num_i = 16'h0010; wb_pc_i = 32'h1C000100;
      wb_we_i = 1; wb_waddr_i = 5'd4;
      step();
      chk("excp_code_const", excp_code_o, 4);
      chk("excp_rpc_const", redirect_pc_o, 32'h1C008000);
      garbage_in();
      repeat (2) step();
      clear_in();
      step();

      // Interrupt beats exception; without valid nothing happens.
      wb_valid_i = 1; wb_excp_i = 1; wb_excp_num_i = 16'h0003; int_pending_i = 1; wb_pc_i = 32'h1C000110;
      step();
      chk("int_code_const", excp_code_o, 4'hF);
      clear_in();
      repeat (2) step();
      int_pending_i = 1; wb_excp_i = 1;
      repeat (2) step();

      // ERTN clears LLbit; refetch wraps.
      clear_in();
      wb_valid_i = 1; wb_llbit_we_i = 1; wb_llbit_value_i = 1;
      step();
      clear_in();
      wb_valid_i = 1; wb_ertn_i = 1;
      step();
      chk("ertn_llbit_const", llbit_o, 0);
      clear_in();
      repeat (2) step();
      wb_valid_i = 1; wb_refetch_i = 1; wb_pc_i = 32'hFFFFFFFC;
      step();
      chk("refetch_wrap_const", redirect_pc_o, 32'h0);
      clear_in();
      repeat (2) step();

      // IDLE sleep and interrupt wake.
      wb_valid_i = 1; wb_idle_i = 1; wb_pc_i = 32'h1C000300;
      step();
      clear_in();
      repeat (10) step();
      int_pending_i = 1;
      step();
      chk("wake_epc_const", excp_pc_o, 32'h1C000304);
      clear_in();
      repeat (3) step();

      // Asynchronous reset during IDLE and during FLUSH.
      wb_valid_i = 1; wb_idle_i = 1; wb_pc_i = 32'h1C000400;
      step();
      clear_in();
      step();
      mid_cycle_reset("rst_idle");
      step();
      wb_valid_i = 1; wb_excp_i = 1; wb_excp_num_i = 16'h8000;
      step();
      mid_cycle_reset("rst_flush");
      step();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         wb_valid_i       = ($urandom % 4) != 0;
         int_pending_i    = ($urandom % 12) == 0;
         wb_excp_i        = ($urandom % 10) == 0;
         wb_excp_num_i    = (($urandom % 8) == 0) ? 16'd0 : (16'($urandom) & 16'($urandom));
         wb_ertn_i        = ($urandom % 16) == 0;
         wb_refetch_i     = ($urandom % 16) == 0;
         wb_idle_i        = ($urandom % 20) == 0;
         wb_we_i          = $urandom % 2;
         wb_waddr_i       = 5'($urandom);
         wb_wdata_i       = $urandom;
         wb_llbit_we_i    = ($urandom % 3) == 0;
         wb_llbit_value_i = $urandom % 2;
         wb_pc_i          = $urandom;
         csr_eentry_i     = $urandom;
         csr_era_i        = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
